// File: rtl/pe_os_int.sv
// Signed-integer output-stationary systolic PE: operand forwarding,
// tile accumulation with optional saturation, and a valid/ready drain chain.
module pe_os_int #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic              out_last,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_in_valid,
  output logic              drain_in_ready,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_out_valid,
  input  logic              drain_out_ready,
  output logic              drain_out_ovf
);

  localparam int PW = 2 * DATA_W;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic                    ovf_sticky;
  logic [ACC_W-1:0]        res;
  logic                    res_ovf;
  logic                    res_full;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W:0]   sum;
  logic                    beat_ovf;
  logic [ACC_W-1:0]        sum_fix;

  logic accept;
  logic load_ok;
  logic load_own;
  logic load_up;

  assign prod = PW'($signed(in_a)) * PW'($signed(in_b));
  assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);

  // One guard bit: overflow iff the two top bits of the sum disagree.
  assign beat_ovf = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    sum_fix = sum[ACC_W-1:0];
    if (SATURATE && beat_ovf) begin
      sum_fix = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign in_ready = !(in_last && res_full);
  assign accept   = in_valid && in_ready;

  assign load_ok        = !drain_out_valid || drain_out_ready;
  assign load_own       = load_ok && res_full;
  assign load_up        = load_ok && !res_full && drain_in_valid;
  assign drain_in_ready = load_ok && !res_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_a    <= in_a;
        out_b    <= in_b;
        out_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= sum_fix;
        ovf_sticky <= ovf_sticky | beat_ovf;
      end
    end
  end

  // A last beat can never be accepted while res_full, so set and clear
  // of the result register never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      res      <= '0;
      res_ovf  <= 1'b0;
      res_full <= 1'b0;
    end else begin
      if (load_own) begin
        res_full <= 1'b0;
      end
      if (accept && in_last) begin
        res      <= sum_fix;
        res_ovf  <= ovf_sticky | beat_ovf;
        res_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_out       <= '0;
      drain_out_ovf   <= 1'b0;
      drain_out_valid <= 1'b0;
    end else if (load_own) begin
      drain_out       <= res;
      drain_out_ovf   <= res_ovf;
      drain_out_valid <= 1'b1;
    end else if (load_up) begin
      drain_out       <= drain_in;
      drain_out_ovf   <= 1'b0;
      drain_out_valid <= 1'b1;
    end else if (drain_out_ready) begin
      drain_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_os_int.sv
// Directed bench for pe_os_int: saturating and wrapping instances share
// stimulus; a negedge monitor scores forwarding and drain order.
module tb_pe_os_int;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;

  typedef struct packed {
    logic [AW-1:0] v;
    logic          o;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_valid;
  logic          in_last;
  logic [AW-1:0] drain_in;
  logic          drain_in_valid;
  logic          drain_out_ready;

  logic          in_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_valid;
  logic          out_last;
  logic          drain_in_ready;
  logic [AW-1:0] drain_out;
  logic          drain_out_valid;
  logic          drain_out_ovf;

  logic          w_in_ready;
  logic [DW-1:0] w_out_a;
  logic [DW-1:0] w_out_b;
  logic          w_out_valid;
  logic          w_out_last;
  logic          w_drain_in_ready;
  logic [AW-1:0] w_drain_out;
  logic          w_drain_out_valid;
  logic          w_drain_out_ovf;

  int vectors = 0;
  int miscompares = 0;

  exp_t qs[$];
  exp_t qw[$];
  longint ms, mw;
  bit     so, wo;
  bit     armed = 0;
  logic          fv, fl;
  logic [DW-1:0] fa, fb;
  logic          held_v;
  logic [AW-1:0] held_d;

  pe_os_int #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b),
    .out_valid(out_valid), .out_last(out_last),
    .drain_in(drain_in), .drain_in_valid(drain_in_valid),
    .drain_in_ready(drain_in_ready),
    .drain_out(drain_out), .drain_out_valid(drain_out_valid),
    .drain_out_ready(drain_out_ready),
    .drain_out_ovf(drain_out_ovf)
  );

  pe_os_int #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .in_last(in_last),
    .in_ready(w_in_ready),
    .out_a(w_out_a), .out_b(w_out_b),
    .out_valid(w_out_valid), .out_last(w_out_last),
    .drain_in(drain_in), .drain_in_valid(drain_in_valid),
    .drain_in_ready(w_drain_in_ready),
    .drain_out(w_drain_out), .drain_out_valid(w_drain_out_valid),
    .drain_out_ready(drain_out_ready),
    .drain_out_ovf(w_drain_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      armed = 1;
      qs.delete();
      qw.delete();
      ms = 0; mw = 0; so = 0; wo = 0;
      fv = 0; fl = 0; fa = '0; fb = '0;
      held_v = 0; held_d = '0;
    end else if (armed) begin
      chk("fwd_valid", 64'(out_valid), 64'(fv));
      chk("fwd_a", 64'(out_a), 64'(fa));
      chk("fwd_b", 64'(out_b), 64'(fb));
      chk("fwd_last", 64'(out_last), 64'(fl));
      chk("w_fwd_valid", 64'(w_out_valid), 64'(fv));
      chk("w_fwd_a", 64'(w_out_a), 64'(fa));
      chk("w_fwd_b", 64'(w_out_b), 64'(fb));
      chk("w_fwd_last", 64'(w_out_last), 64'(fl));
      if (held_v) begin
        chk("hold_valid", 64'(drain_out_valid), 64'(1));
        chk("hold_data", 64'(drain_out), 64'(held_d));
      end
      if (drain_out_valid && drain_out_ready) begin
        if (qs.size() == 0) begin
          chk("drain_extra", 64'(qs.size()), 64'(1));
        end else begin
          exp_t e;
          e = qs.pop_front();
          chk("drain_s", 64'(drain_out), 64'(e.v));
          chk("ovf_s", 64'(drain_out_ovf), 64'(e.o));
        end
      end
      if (w_drain_out_valid && drain_out_ready) begin
        if (qw.size() == 0) begin
          chk("w_drain_extra", 64'(qw.size()), 64'(1));
        end else begin
          exp_t e;
          e = qw.pop_front();
          chk("drain_w", 64'(w_drain_out), 64'(e.v));
          chk("ovf_w", 64'(w_drain_out_ovf), 64'(e.o));
        end
      end
      held_v = drain_out_valid && !drain_out_ready;
      held_d = drain_out;
      if (drain_in_valid && drain_in_ready) begin
        qs.push_back('{v: drain_in, o: 1'b0});
        qw.push_back('{v: drain_in, o: 1'b0});
      end
      if (in_valid && in_ready) begin
        longint p, s, sw;
        bit ov, owv;
        logic signed [AW-1:0] t;
        p  = longint'($signed(in_a)) * longint'($signed(in_b));
        s  = ms + p;
        ov = (s > MAXV) || (s < MINV);
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        sw  = mw + p;
        owv = (sw > MAXV) || (sw < MINV);
        t   = sw[AW-1:0];
        if (in_last) begin
          qs.push_back('{v: s[AW-1:0], o: so | ov});
          qw.push_back('{v: t, o: wo | owv});
          ms = 0; mw = 0; so = 0; wo = 0;
        end else begin
          ms = s; mw = longint'(t);
          so = so | ov; wo = wo | owv;
        end
        fv = 1; fa = in_a; fb = in_b; fl = in_last;
      end else begin
        fv = 0;
      end
    end
  end

  task automatic beat(input int a, input int b, input bit last);
    int n;
    n = 0;
    in_a = 16'(a); in_b = 16'(b);
    in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("beat_accept", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_dov();
    int n;
    n = 0;
    while (!drain_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("dov_timeout", 64'(drain_out_valid), 64'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qs.size() != 0 || drain_out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", 64'(qs.size()), 64'(0));
    chk("w_drain_left", 64'(qw.size()), 64'(0));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_a"}, 64'(out_a), 64'(0));
    chk({tag, "_out_b"}, 64'(out_b), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_drain"}, 64'(drain_out), 64'(0));
    chk({tag, "_dov"}, 64'(drain_out_valid), 64'(0));
    chk({tag, "_ovf"}, 64'(drain_out_ovf), 64'(0));
    chk({tag, "_w_drain"}, 64'(w_drain_out), 64'(0));
    chk({tag, "_w_dov"}, 64'(w_drain_out_valid), 64'(0));
    chk({tag, "_in_rdy"}, 64'(in_ready), 64'(1));
    chk({tag, "_din_rdy"}, 64'(drain_in_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_a = '0; in_b = '0; in_valid = 1'b0; in_last = 1'b0;
    drain_in = '0; drain_in_valid = 1'b0; drain_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; #1;
    check_zero("reset");

    // Basic tile: 6 - 20 + 49 = 35
    beat(2, 3, 0); beat(-4, 5, 0); beat(7, 7, 1);
    wait_drain();

    // Back-to-back tiles with the drain stalled
    drain_out_ready = 1'b0;
    beat(1, 1, 0); beat(1, 1, 1);
    in_a = 16'd3; in_b = 16'd3; in_last = 1'b1; in_valid = 1'b1; #1;
    chk("t2_stall", 64'(in_ready), 64'(0));
    @(posedge clk); #2;
    chk("t2_rdy", 64'(in_ready), 64'(1));
    chk("t2_park", 64'(drain_out), 64'(2));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain_out_ready = 1'b1;
    wait_drain();

    // Backpressure with an upstream result waiting
    drain_out_ready = 1'b0;
    beat(4, 4, 1); beat(1, 2, 1);
    drain_in = 32'h123; drain_in_valid = 1'b1;
    in_a = 16'd1; in_b = 16'd1; in_last = 1'b0; in_valid = 1'b1; #1;
    chk("t3_din_rdy", 64'(drain_in_ready), 64'(0));
    chk("t3_rdy_nonlast", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_last = 1'b1; #1;
    chk("t3_rdy_last", 64'(in_ready), 64'(0));
    chk("t3_din_rdy2", 64'(drain_in_ready), 64'(0));
    chk("t3_hold", 64'(drain_out), 64'(16));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain_out_ready = 1'b1; #1;
    begin
      int n;
      n = 0;
      while (!drain_in_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("t3_din_accept", 64'(drain_in_ready), 64'(1));
    end
    @(posedge clk); #1;
    drain_in_valid = 1'b0;
    beat(1, 1, 1);
    wait_drain();

    // Positive overflow: sat 0x7FFFFFFF, wrap 0xBFFD0003
    drain_out_ready = 1'b0;
    beat(32767, 32767, 0); beat(32767, 32767, 0);
    beat(32767, 32767, 1);
    wait_dov();
    chk("t4_sat", 64'(drain_out), 64'h7FFF_FFFF);
    chk("t4_sat_ovf", 64'(drain_out_ovf), 64'(1));
    chk("t4_wrap", 64'(w_drain_out), 64'hBFFD_0003);
    chk("t4_wrap_ovf", 64'(w_drain_out_ovf), 64'(1));
    beat(1, 1, 1);
    drain_out_ready = 1'b1;
    wait_drain();

    // Negative overflow: sat 0x80000000, wrap 0x40018000
    drain_out_ready = 1'b0;
    beat(-32768, 32767, 0); beat(-32768, 32767, 0);
    beat(-32768, 32767, 1);
    wait_dov();
    chk("t5_sat", 64'(drain_out), 64'h8000_0000);
    chk("t5_sat_ovf", 64'(drain_out_ovf), 64'(1));
    chk("t5_wrap", 64'(w_drain_out), 64'h4001_8000);
    drain_out_ready = 1'b1;
    wait_drain();

    // Reset mid-tile, then mid-drain
    beat(1, 1, 0); beat(1, 1, 0);
    pulse_rst();
    check_zero("t6_tile");
    drain_out_ready = 1'b0;
    beat(2, 2, 1);
    wait_dov();
    pulse_rst();
    check_zero("t6_drain");
    drain_out_ready = 1'b1;
    beat(5, 5, 1);
    wait_dov();
    chk("t6_result", 64'(drain_out), 64'(25));
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
